// File: rtl/arith_seq_pkg.sv
// arith_seq_pkg: shared states, op codes and sizing for the arith_seq micro-op sequencer.
package arith_seq_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ADD,
        S_SHR_BC,
        S_SHL_B,
        S_SHR_ONLY,
        S_DONE
    } state_t;
    localparam logic [1:0] OP_MUL = 2'b00;
    localparam logic [1:0] OP_SHL = 2'b01;
    localparam logic [1:0] OP_SHR = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;
    localparam int MUL_STEPS_DEF = 30;
    localparam int CNT_W = 6;
endpackage

// File: rtl/arith_seq_step_cnt.sv
// arith_seq_step_cnt: loadable down counter that saturates at zero and flags value==1.
module arith_seq_step_cnt
    import arith_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_val,
    input  logic             i_dec,
    output logic             o_last,
    output logic             o_zero
);
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && !o_zero)
            r_cnt <= r_cnt - 1'b1;
    end
    assign o_last = r_cnt == CNT_W'(1);
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/arith_seq.sv
// arith_seq: issues one arithmetic-unit strobe per clock for MUL/SHL/SHR commands.
// Define ARITH_SEQ_OVF_EN to stop a left shift early when B overflows and flag ovf.
module arith_seq
    import arith_seq_pkg::*;
#(
    parameter int MUL_STEPS = MUL_STEPS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [4:0] count,
    input  logic       reg_c_30,
    input  logic       reg_b_0,
    output logic       do_clear_b,
    output logic       do_sum,
    output logic       do_left_shift_b,
    output logic       do_right_shift_bc,
    output logic       busy,
    output logic       done,
    output logic       ovf
);
    state_t           r_state, w_next;
    logic             r_ovf;
    logic             w_accept, w_dec, w_last, w_zero, w_end, w_ovf_hit;
    logic [CNT_W-1:0] w_load_val;

    assign w_accept   = r_state == S_IDLE && start;
    assign w_load_val = op == OP_MUL ? CNT_W'(MUL_STEPS) : CNT_W'(count);
    assign w_dec      = r_state inside {S_SHR_BC, S_SHL_B, S_SHR_ONLY};
    assign w_end      = w_last || w_zero;

    arith_seq_step_cnt u_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_accept),
        .i_val  (w_load_val),
        .i_dec  (w_dec),
        .o_last (w_last),
        .o_zero (w_zero)
    );

`ifdef ARITH_SEQ_OVF_EN
    assign w_ovf_hit = r_state == S_SHL_B && reg_b_0;
`else
    logic w_unused;
    assign w_ovf_hit = 1'b0;
    assign w_unused  = reg_b_0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_ovf   <= w_accept ? 1'b0 : (w_ovf_hit ? 1'b1 : r_ovf);
        end
    end

    always_comb begin
        w_next            = r_state;
        do_clear_b        = 1'b0;
        do_sum            = 1'b0;
        do_left_shift_b   = 1'b0;
        do_right_shift_bc = 1'b0;
        busy              = r_state != S_IDLE;
        done              = r_state == S_DONE;
        case (r_state)
            S_IDLE:
                if (start)
                    w_next = op == OP_MUL ? S_PREP :
                             (op == OP_NOP || count == '0) ? S_DONE :
                             op == OP_SHL ? S_SHL_B : S_SHR_ONLY;
            S_PREP: begin
                do_clear_b = 1'b1;
                w_next     = S_ADD;
            end
            S_ADD: begin
                do_sum = reg_c_30;
                w_next = S_SHR_BC;
            end
            S_SHR_BC: begin
                do_right_shift_bc = 1'b1;
                w_next            = w_end ? S_DONE : S_ADD;
            end
            // an overflowing left shift is dropped and the remaining count discarded
            S_SHL_B: begin
                do_left_shift_b = !w_ovf_hit;
                w_next          = (w_end || w_ovf_hit) ? S_DONE : S_SHL_B;
            end
            S_SHR_ONLY: begin
                do_right_shift_bc = 1'b1;
                w_next            = w_end ? S_DONE : S_SHR_ONLY;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign ovf = r_ovf;
endmodule

// File: tb/tb_arith_seq.sv
// tb_arith_seq: scoreboard bench; expected per-cycle outputs are queued then compared cycle by cycle.
module tb_arith_seq;
    logic       clk = 1'b0;
    logic       reset, start, reg_c_30, reg_b_0;
    logic [1:0] op;
    logic [4:0] count;
    logic       do_clear_b, do_sum, do_left_shift_b, do_right_shift_bc, busy, done, ovf;
    int         checks = 0;
    int         failures = 0;
    logic [6:0] q[$];
    logic [6:0] obs, exp_v;
    localparam int MUL_DONE = 2 * 30 + 2;

    arith_seq dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .op                (op),
        .count             (count),
        .reg_c_30          (reg_c_30),
        .reg_b_0           (reg_b_0),
        .do_clear_b        (do_clear_b),
        .do_sum            (do_sum),
        .do_left_shift_b   (do_left_shift_b),
        .do_right_shift_bc (do_right_shift_bc),
        .busy              (busy),
        .done              (done),
        .ovf               (ovf)
    );

    always #5 clk = ~clk;
    // bit order: clear, sum, lsh, rsh, busy, done, ovf
    assign obs = {do_clear_b, do_sum, do_left_shift_b, do_right_shift_bc, busy, done, ovf};

    function automatic logic [6:0] mul_exp(input int k, input logic cbit);
        return k == 1 ? 7'b1000100 :
               k == MUL_DONE ? 7'b0000110 :
               k > MUL_DONE ? 7'b0000000 :
               (k % 2 == 1) ? 7'b0001100 : {1'b0, cbit, 5'b00100};
    endfunction

    task automatic kick(input logic [1:0] o, input logic [4:0] n);
        start = 1'b1;
        op    = o;
        count = n;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; op = 2'b00; count = '0; reg_c_30 = 1'b0; reg_b_0 = 1'b0;
        q.push_back(7'b0);
        repeat (2) @(posedge clk);
        #2;
        checks++;
        exp_v = q.pop_front();
        if (obs !== exp_v) begin failures++; $display("FAIL reset got %b want %b", obs, exp_v); end
        reset = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_mul;
        logic [29:0] c_exp = 30'b101, c_drv = 30'b101;
        int rsh_n = 0, sum_n = 0;
        for (int k = 1; k <= MUL_DONE + 1; k++) begin
            q.push_back(mul_exp(k, c_exp[0]));
            if (k % 2 == 1 && k >= 3 && k < MUL_DONE) c_exp = c_exp >> 1;
        end
        kick(2'b00, 5'd7);
        for (int k = 1; k <= MUL_DONE + 1; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reg_c_30 = c_drv[0];
            #1;
            rsh_n += int'(do_right_shift_bc);
            sum_n += int'(do_sum);
            checks++;
            exp_v = q.pop_front();
            if (obs !== exp_v) begin failures++; $display("FAIL mul cycle %0d got %b want %b", k, obs, exp_v); end
            if (k % 2 == 1 && k >= 3 && k < MUL_DONE) c_drv = c_drv >> 1;
        end
        checks++;
        if (rsh_n !== 30) begin failures++; $display("FAIL mul_rsh_count got %0d want 30", rsh_n); end
        checks++;
        if (sum_n !== 2) begin failures++; $display("FAIL mul_sum_count got %0d want 2", sum_n); end
        reg_c_30 = 1'b0;
    endtask

    task automatic test_shr5;
        for (int k = 1; k <= 5; k++) q.push_back(7'b0001100);
        q.push_back(7'b0000110);
        q.push_back(7'b0000000);
        kick(2'b10, 5'd5);
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            #1;
            checks++;
            exp_v = q.pop_front();
            if (obs !== exp_v) begin failures++; $display("FAIL shr5 cycle %0d got %b want %b", k, obs, exp_v); end
        end
    endtask

    task automatic test_zero;
        for (int t = 0; t < 2; t++) begin
            q.push_back(7'b0000110);
            q.push_back(7'b0000000);
            if (t == 0) kick(2'b01, 5'd0); else kick(2'b11, 5'd9);
            for (int k = 1; k <= 2; k++) begin
                @(posedge clk); #1;
                start = 1'b0;
                #1;
                checks++;
                exp_v = q.pop_front();
                if (obs !== exp_v) begin failures++; $display("FAIL zero%0d cycle %0d got %b want %b", t, k, obs, exp_v); end
            end
        end
    endtask

    task automatic test_ovf;
        int n;
`ifdef ARITH_SEQ_OVF_EN
        n = 5;
        for (int k = 1; k <= 3; k++) q.push_back(7'b0010100);
        q.push_back(7'b0000100);
        q.push_back(7'b0000111);
`else
        n = 11;
        for (int k = 1; k <= 10; k++) q.push_back(7'b0010100);
        q.push_back(7'b0000110);
`endif
        kick(2'b01, 5'd10);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reg_b_0 = k >= 4;
            #1;
            checks++;
            exp_v = q.pop_front();
            if (obs !== exp_v) begin failures++; $display("FAIL ovf cycle %0d got %b want %b", k, obs, exp_v); end
        end
        reg_b_0 = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_restart;
        for (int k = 1; k <= MUL_DONE + 1; k++) q.push_back(mul_exp(k, 1'b0));
        q.push_back(7'b0001100);
        q.push_back(7'b0000110);
        q.push_back(7'b0000000);
        kick(2'b00, 5'd0);
        for (int k = 1; k <= MUL_DONE + 4; k++) begin
            @(posedge clk); #1;
            start = k == 3 || k == MUL_DONE || k == MUL_DONE + 1;
            op    = k == MUL_DONE + 1 ? 2'b10 : 2'b00;
            count = k == MUL_DONE + 1 ? 5'd1 : 5'd4;
            #1;
            checks++;
            exp_v = q.pop_front();
            if (obs !== exp_v) begin failures++; $display("FAIL restart cycle %0d got %b want %b", k, obs, exp_v); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid;
        for (int k = 1; k <= 20; k++) q.push_back(mul_exp(k, 1'b0));
        q.push_back(7'b0000000);
        q.push_back(7'b0000000);
        q.push_back(7'b0001100);
        q.push_back(7'b0000110);
        q.push_back(7'b0000000);
        kick(2'b00, 5'd0);
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk); #1;
            reset = k == 20;
            start = k == 22;
            op    = k == 22 ? 2'b10 : 2'b00;
            count = 5'd1;
            #1;
            checks++;
            exp_v = q.pop_front();
            if (obs !== exp_v) begin failures++; $display("FAIL reset_mid cycle %0d got %b want %b", k, obs, exp_v); end
        end
    endtask

    initial begin
        test_reset;
        test_mul;
        test_shr5;
        test_zero;
        test_ovf;
        test_restart;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
